// File: rtl/demux_frame_sequencer_pkg.sv
// Shared constants and FSM state encoding for the demux frame sequencer.
package demux_seq_pkg;

  localparam int SEL_W_DEF       = 4;
  localparam int PAYLOAD_LEN_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    PAR,
    EMIT
  } state_t;

endpackage

// File: rtl/demux_frame_sequencer_shift.sv
// Payload buffer: serial MSB-first load from sdi, MSB-first shift-out on advance.
module frame_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_en,
  input  logic advance,
  input  logic sdi,
  output logic msb
);

  logic [WIDTH-1:0] data;

  // Loading and advancing both shift toward the MSB; only the fill bit differs.
  always_ff @(posedge clk) begin
    if (!rst_n)
      data <= '0;
    else if (load_en)
      data <= (data << 1) | WIDTH'(sdi);
    else if (advance)
      data <= data << 1;
  end

  assign msb = data[WIDTH-1];

endmodule

// File: rtl/demux_frame_sequencer.sv
// Deserialises an address+payload frame from sdi and replays it bitwise to the demux
// under valid/ready. Optional parity check enabled by defining DEMUX_SEQ_PARITY_EN.
module demux_frame_sequencer
  import demux_seq_pkg::*;
#(
  parameter int SEL_W       = SEL_W_DEF,
  parameter int PAYLOAD_LEN = PAYLOAD_LEN_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sdi,
  output logic             busy,
  output logic [SEL_W-1:0] sel,
  output logic             din,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             frame_done,
  output logic             parity_err
);

  localparam int CNT_W = $clog2(((SEL_W > PAYLOAD_LEN) ? SEL_W : PAYLOAD_LEN) + 1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(SEL_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(PAYLOAD_LEN - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [SEL_W-1:0] addr_sr;
  logic [SEL_W-1:0] sel_q;
  logic             done_q;
  logic             load_en;
  logic             advance;
  logic             xfer;
  logic             payload_msb;

`ifdef DEMUX_SEQ_PARITY_EN
  logic par_acc;
  logic perr_q;
  logic parity_ok;

  // Running parity over address and payload; the PAR bit must make the total even.
  assign parity_ok = ~(par_acc ^ sdi);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      par_acc <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      if (state == IDLE)
        par_acc <= 1'b0;
      else if (state == ADDR || state == DATA)
        par_acc <= par_acc ^ sdi;
      perr_q <= (state == PAR) && !parity_ok;
    end
  end

  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    load_en   = 1'b0;
    advance   = 1'b0;
    xfer      = (state == EMIT) && out_ready;
    unique case (state)
      IDLE: if (start) state_nxt = ADDR;
      ADDR: if (cnt == ADDR_LAST) state_nxt = DATA;
      DATA: begin
        load_en = 1'b1;
        if (cnt == DATA_LAST)
`ifdef DEMUX_SEQ_PARITY_EN
          state_nxt = PAR;
`else
          state_nxt = EMIT;
`endif
      end
      PAR: begin
`ifdef DEMUX_SEQ_PARITY_EN
        state_nxt = parity_ok ? EMIT : IDLE;
`else
        state_nxt = IDLE;
`endif
      end
      EMIT: begin
        advance = xfer;
        if (xfer && cnt == DATA_LAST) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The counter restarts on every state change; sel only updates on entry to EMIT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_sr <= '0;
      sel_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)
        cnt <= '0;
      else if (state == ADDR || state == DATA || xfer)
        cnt <= cnt + CNT_W'(1);
      if (state == ADDR)
        addr_sr <= (addr_sr << 1) | SEL_W'(sdi);
      if (state_nxt == EMIT && state != EMIT)
        sel_q <= addr_sr;
      done_q <= (state == EMIT) && (state_nxt == IDLE);
    end
  end

  frame_shift_reg #(
    .WIDTH(PAYLOAD_LEN)
  ) u_payload (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_en(load_en),
    .advance(advance),
    .sdi    (sdi),
    .msb    (payload_msb)
  );

  assign busy       = (state != IDLE);
  assign out_valid  = (state == EMIT);
  assign din        = out_valid & payload_msb;
  assign sel        = sel_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_demux_frame_sequencer.sv
// Directed self-checking bench for demux_frame_sequencer; parity cases run when
// DEMUX_SEQ_PARITY_EN is defined.
module tb_demux_frame_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       sdi;
  logic       busy;
  logic [3:0] sel;
  logic       din;
  logic       out_valid;
  logic       out_ready;
  logic       frame_done;
  logic       parity_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  demux_frame_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .sdi       (sdi),
    .busy      (busy),
    .sel       (sel),
    .din       (din),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_done(frame_done),
    .parity_err(parity_err)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives start, the address and the payload (plus the parity bit when enabled).
  // poke_data >= 0 raises start during that payload bit to show it is ignored.
  task automatic applyStimulus(input logic [3:0] addr, input logic [7:0] payload,
                               input logic par_flip, input int poke_data);
    start = 1'b1;
    sdi   = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      sdi = addr[i];
      tick();
    end
    for (int i = 7; i >= 0; i--) begin
      sdi   = payload[i];
      start = (7 - i == poke_data);
      tick();
    end
    start = 1'b0;
    sdi   = (^{addr, payload}) ^ par_flip;
`ifdef DEMUX_SEQ_PARITY_EN
    tick();
`endif
    sdi = 1'b0;
  endtask

  // Consumes one emitted frame, optionally stalling, poking start or resetting mid-frame.
  task automatic collectFrame(input string tag, input logic [3:0] exp_addr,
                              input logic [7:0] exp_payload, input int stall_bit,
                              input int stall_cycles, input int poke_at, input int reset_at);
    int k = 0;
    int stalled = 0;
    while (k < 8) begin
      if (k == reset_at) begin
        rst_n = 1'b0;
        tick();
        checkOutput({tag, "_rst_valid"}, out_valid, 0);
        checkOutput({tag, "_rst_busy"}, busy, 0);
        checkOutput({tag, "_rst_sel"}, sel, 0);
        checkOutput({tag, "_rst_din"}, din, 0);
        checkOutput({tag, "_rst_done"}, frame_done, 0);
        checkOutput({tag, "_rst_perr"}, parity_err, 0);
        rst_n = 1'b1;
        return;
      end
      checkOutput({tag, "_valid"}, out_valid, 1);
      checkOutput({tag, "_sel"}, sel, exp_addr);
      checkOutput({tag, "_din"}, din, exp_payload[7-k]);
      start = (k == poke_at);
      if (k == stall_bit && stalled < stall_cycles) begin
        out_ready = 1'b0;
        stalled++;
      end else begin
        out_ready = 1'b1;
        k++;
      end
      tick();
    end
    start     = 1'b0;
    out_ready = 1'b1;
    checkOutput({tag, "_done"}, frame_done, 1);
    checkOutput({tag, "_valid_end"}, out_valid, 0);
    checkOutput({tag, "_busy_end"}, busy, 0);
    checkOutput({tag, "_din_end"}, din, 0);
    checkOutput({tag, "_sel_end"}, sel, exp_addr);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    sdi       = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_valid", out_valid, 0);
    checkOutput("reset_sel", sel, 0);
    checkOutput("reset_din", din, 0);
    checkOutput("reset_done", frame_done, 0);
    checkOutput("reset_perr", parity_err, 0);
    rst_n = 1'b1;
    tick();

    $display("[TB] T1 basic frame");
    applyStimulus(4'd5, 8'hA5, 1'b0, -1);
    collectFrame("t1", 4'd5, 8'b1010_0101, -1, 0, -1, -1);
    tick();
    checkOutput("t1_done_pulse", frame_done, 0);

    $display("[TB] T2 stall at bit 2");
    applyStimulus(4'd10, 8'h3C, 1'b0, -1);
    collectFrame("t2", 4'd10, 8'b0011_1100, 2, 3, -1, -1);

    $display("[TB] T3 back-to-back frames");
    tick();
    applyStimulus(4'd0, 8'hFF, 1'b0, -1);
    collectFrame("t3a", 4'd0, 8'hFF, -1, 0, -1, -1);
    applyStimulus(4'd15, 8'h01, 1'b0, -1);
    collectFrame("t3b", 4'd15, 8'h01, -1, 0, -1, -1);

    $display("[TB] T4 start while busy");
    tick();
    applyStimulus(4'd9, 8'h6B, 1'b0, 4);
    collectFrame("t4", 4'd9, 8'b0110_1011, -1, 0, 3, -1);
    tick();
    checkOutput("t4_idle_after", busy, 0);
    checkOutput("t4_no_valid", out_valid, 0);

    $display("[TB] T5 reset during emit");
    applyStimulus(4'd3, 8'hC6, 1'b0, -1);
    collectFrame("t5", 4'd3, 8'hC6, -1, 0, -1, 4);
    tick();
    applyStimulus(4'd7, 8'h81, 1'b0, -1);
    collectFrame("t5b", 4'd7, 8'b1000_0001, -1, 0, -1, -1);

`ifdef DEMUX_SEQ_PARITY_EN
    $display("[TB] T6 parity");
    tick();
    applyStimulus(4'd6, 8'h5A, 1'b0, -1);
    collectFrame("t6ok", 4'd6, 8'h5A, -1, 0, -1, -1);
    checkOutput("t6ok_perr", parity_err, 0);
    tick();
    applyStimulus(4'd12, 8'h33, 1'b1, -1);
    checkOutput("t6bad_perr", parity_err, 1);
    checkOutput("t6bad_valid", out_valid, 0);
    checkOutput("t6bad_busy", busy, 0);
    checkOutput("t6bad_done", frame_done, 0);
    tick();
    checkOutput("t6bad_perr_pulse", parity_err, 0);
    checkOutput("t6bad_valid2", out_valid, 0);
`else
    checkOutput("perr_tied", parity_err, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
